// File: rtl/param_shift_add_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH product of the latched S operand and
// register B, left in {A,B}. One multiplier bit is retired per cycle. Signed mode keeps
// an extra sign bit X so the partial product is WIDTH+1 bits wide and never overflows.
module param_shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clearA_loadB,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] S,
    output logic             x,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    count_q, count_d;

    // Datapath for one compute step
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic             last_step;

    // Partial-product add: in signed mode the final multiplier bit carries negative
    // weight, so the multiplicand is subtracted on the last step instead of added.
    always_comb begin
        last_step = (count_q == LastCount);
        ext       = {m_q[WIDTH-1] & mode_q, m_q};
        acc       = {x_q & mode_q, a_q};
        addend    = '0;
        if (b_q[0]) begin
            if (mode_q && last_step) begin
                addend = ~ext + (WIDTH+1)'(1);
            end else begin
                addend = ext;
            end
        end
        sum = acc + addend;
    end

    // Next-state and register updates for the IDLE/COMPUTE/HOLD sequence
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        mode_d  = mode_q;
        count_d = count_q;

        unique case (state_q)
            StIdle: begin
                // Load wins over a simultaneous start request
                if (!clearA_loadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = S;
                end else if (!run) begin
                    m_d     = S;
                    mode_d  = signed_mode;
                    a_d     = '0;
                    x_d     = 1'b0;
                    count_d = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                x_d = mode_q ? sum[WIDTH] : 1'b0;
                a_d = sum[WIDTH:1];
                b_d = {sum[0], b_q[WIDTH-1:1]};
                if (last_step) begin
                    state_d = StHold;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            StHold: begin
                if (!clearA_loadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = S;
                end
                // Only a released run returns to IDLE, so a held run cannot restart
                if (run) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    // Status and result outputs straight from registers
    always_comb begin
        x    = x_q;
        Aval = a_q;
        Bval = b_q;
        busy = (state_q == StCompute);
        done = (state_q == StHold);
    end

endmodule
